pipe_alu_gen: RTL and testbench

Parametrised successor to the team's four-stage register/memory pipelined ALU. It runs on a single clock, reads two operands from an internal register bank, executes one of 16 operations, writes the result back to the bank, and stores it to an internal data memory. Over the previous generation it adds a valid qualifier, a global stall, EX/WB operand forwarding, result flags, and debug read ports. It sits between the instruction sequencer and the data-memory subsystem.

---
 rtl/pipe_alu_pkg.sv | 26 ++
 rtl/pipe_alu_exec.sv | 78 +++++++
 rtl/pipe_alu_gen.sv | 141 ++++++++++++++
 tb/tb_pipe_alu_gen.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_alu_pkg.sv
// Shared opcode encodings and flag bit positions for the pipelined ALU.
package pipe_alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_PASA = 4'd3;
  localparam logic [3:0] OP_PASB = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_NEGA = 4'd8;
  localparam logic [3:0] OP_NEGB = 4'd9;
  localparam logic [3:0] OP_SRL  = 4'd10;
  localparam logic [3:0] OP_SLL  = 4'd11;
  localparam logic [3:0] OP_SRA  = 4'd12;
  localparam logic [3:0] OP_ROL  = 4'd13;
  localparam logic [3:0] OP_NOT  = 4'd14;
  localparam logic [3:0] OP_SLT  = 4'd15;

  localparam int FLAG_NEG   = 3;
  localparam int FLAG_ZERO  = 2;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_OVF   = 0;

endpackage

// File: rtl/pipe_alu_exec.sv
// Combinational execute unit: computes the result and {neg, zero, carry, ovf}
// flags for one instruction.
module pipe_alu_exec
  import pipe_alu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        func,
  output logic [DATA_W-1:0] z,
  output logic [3:0]        flags
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;
  logic [DATA_W-1:0] neg_a;
  logic [DATA_W-1:0] neg_b;
  logic              carry;
  logic              ovf;

  // The extra top bit of diff is the borrow out of a-b.
  assign sum   = {1'b0, a} + {1'b0, b};
  assign diff  = {1'b0, a} - {1'b0, b};
  assign neg_a = '0 - a;
  assign neg_b = '0 - b;

  always_comb begin
    z     = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (func)
      OP_ADD: begin
        z     = sum[MSB:0];
        carry = sum[DATA_W];
        ovf   = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        z     = diff[MSB:0];
        carry = diff[DATA_W];
        ovf   = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      OP_MUL:  z = a * b;
      OP_PASA: z = a;
      OP_PASB: z = b;
      OP_AND:  z = a & b;
      OP_OR:   z = a | b;
      OP_XOR:  z = a ^ b;
      // Negating the most negative value is the only overflow case.
      OP_NEGA: begin
        z   = neg_a;
        ovf = a[MSB] & neg_a[MSB];
      end
      OP_NEGB: begin
        z   = neg_b;
        ovf = b[MSB] & neg_b[MSB];
      end
      OP_SRL:  z = {1'b0, a[MSB:1]};
      OP_SLL:  z = {a[MSB-1:0], 1'b0};
      OP_SRA:  z = {a[MSB], a[MSB:1]};
      OP_ROL:  z = {a[MSB-1:0], a[MSB]};
      OP_NOT:  z = ~a;
      OP_SLT:  z = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      default: z = '0;
    endcase
  end

  always_comb begin
    flags             = '0;
    flags[FLAG_NEG]   = z[MSB];
    flags[FLAG_ZERO]  = (z == '0);
    flags[FLAG_CARRY] = carry;
    flags[FLAG_OVF]   = ovf;
  end

endmodule

// File: rtl/pipe_alu_gen.sv
// Four-stage register/memory ALU pipeline (operand, execute, writeback, store)
// with EX/WB forwarding, global stall and debug read ports.
module pipe_alu_gen
  import pipe_alu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int MEM_AW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              stall,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic [REG_AW-1:0] rd,
  input  logic [3:0]        func,
  input  logic [MEM_AW-1:0] addr,
  output logic              out_valid,
  output logic [DATA_W-1:0] z_out,
  output logic [3:0]        flags,
  input  logic [REG_AW-1:0] dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata,
  input  logic [MEM_AW-1:0] dbg_maddr,
  output logic [DATA_W-1:0] dbg_mdata
);

  localparam int NREG = 2 ** REG_AW;
  localparam int NMEM = 2 ** MEM_AW;

  logic [DATA_W-1:0] regbank [NREG];
  logic [DATA_W-1:0] mem     [NMEM];

  logic              v1;
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;
  logic [REG_AW-1:0] s1_rd;
  logic [3:0]        s1_func;
  logic [MEM_AW-1:0] s1_addr;

  logic [DATA_W-1:0] ex_z;
  logic [3:0]        ex_flags;

  logic              v2;
  logic [DATA_W-1:0] s2_z;
  logic [3:0]        s2_flags;
  logic [REG_AW-1:0] s2_rd;
  logic [MEM_AW-1:0] s2_addr;

  logic              v3;
  logic [DATA_W-1:0] s3_z;
  logic [MEM_AW-1:0] s3_addr;

  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              accept;

  assign accept = in_valid && !stall;

  // Youngest producer wins: the result still in execute beats the one about
  // to be written back, which beats the bank entry.
  always_comb begin
    op_a = regbank[rs1];
    if (v2 && s2_rd == rs1) op_a = s2_z;
    if (v1 && s1_rd == rs1) op_a = ex_z;
    op_b = regbank[rs2];
    if (v2 && s2_rd == rs2) op_b = s2_z;
    if (v1 && s1_rd == rs2) op_b = ex_z;
  end

  pipe_alu_exec #(.DATA_W(DATA_W)) u_exec (
    .a     (s1_a),
    .b     (s1_b),
    .func  (s1_func),
    .z     (ex_z),
    .flags (ex_flags)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_rd     <= '0;
      s1_func   <= '0;
      s1_addr   <= '0;
      v2        <= 1'b0;
      s2_z      <= '0;
      s2_flags  <= '0;
      s2_rd     <= '0;
      s2_addr   <= '0;
      v3        <= 1'b0;
      s3_z      <= '0;
      s3_addr   <= '0;
      out_valid <= 1'b0;
      z_out     <= '0;
      flags     <= '0;
    end else if (!stall) begin
      v1      <= accept;
      s1_a    <= op_a;
      s1_b    <= op_b;
      s1_rd   <= rd;
      s1_func <= func;
      s1_addr <= addr;

      v2       <= v1;
      s2_z     <= ex_z;
      s2_flags <= ex_flags;
      s2_rd    <= s1_rd;
      s2_addr  <= s1_addr;

      v3      <= v2;
      s3_z    <= s2_z;
      s3_addr <= s2_addr;

      // Bubbles leave the last retired result visible.
      out_valid <= v2;
      if (v2) begin
        z_out <= s2_z;
        flags <= s2_flags;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regbank[i] <= '0;
    end else if (!stall && v2) begin
      regbank[s2_rd] <= s2_z;
    end
  end

  // Data memory has no reset; reset still cancels pending stores via v3.
  always_ff @(posedge clk) begin
    if (!stall && v3) mem[s3_addr] <= s3_z;
  end

  assign dbg_rdata = regbank[dbg_raddr];
  assign dbg_mdata = mem[dbg_maddr];

endmodule

// File: tb/tb_pipe_alu_gen.sv
// Directed bench for pipe_alu_gen: reset, load/add, forwarding chain, flags,
// stall freeze and mid-stream reset.
module tb_pipe_alu_gen;

  localparam int DATA_W = 16;
  localparam int REG_AW = 4;
  localparam int MEM_AW = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              stall;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic [REG_AW-1:0] rd;
  logic [3:0]        func;
  logic [MEM_AW-1:0] addr;
  logic              out_valid;
  logic [DATA_W-1:0] z_out;
  logic [3:0]        flags;
  logic [REG_AW-1:0] dbg_raddr;
  logic [DATA_W-1:0] dbg_rdata;
  logic [MEM_AW-1:0] dbg_maddr;
  logic [DATA_W-1:0] dbg_mdata;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [3:0]  func;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [3:0]  rd;
    logic [7:0]  addr;
    logic [15:0] z;
    logic [3:0]  fl;
  } instr_t;

  pipe_alu_gen #(.DATA_W(DATA_W), .REG_AW(REG_AW), .MEM_AW(MEM_AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .stall     (stall),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd),
    .func      (func),
    .addr      (addr),
    .out_valid (out_valid),
    .z_out     (z_out),
    .flags     (flags),
    .dbg_raddr (dbg_raddr),
    .dbg_rdata (dbg_rdata),
    .dbg_maddr (dbg_maddr),
    .dbg_mdata (dbg_mdata)
  );

  always #5 clk = ~clk;

  function automatic instr_t mk(input logic [3:0] f, input logic [3:0] a, input logic [3:0] b,
                                input logic [3:0] d, input logic [7:0] ad,
                                input logic [15:0] z, input logic [3:0] fl);
    instr_t t;
    t.func = f; t.rs1 = a; t.rs2 = b; t.rd = d; t.addr = ad; t.z = z; t.fl = fl;
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input instr_t t);
    in_valid = 1'b1;
    func     = t.func;
    rs1      = t.rs1;
    rs2      = t.rs2;
    rd       = t.rd;
    addr     = t.addr;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; stall = 1'b0;
    rs1 = '0; rs2 = '0; rd = '0; func = '0; addr = '0; dbg_raddr = '0; dbg_maddr = '0;
    tick(); tick();
    n_checks++;
    if (out_valid !== 1'b0 || z_out !== 16'h0 || flags !== 4'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: out_valid=%b z_out=%h flags=%b, expected 0/0000/0000", out_valid, z_out, flags);
    end
    rst_n = 1'b1;
    tick();
    for (int r = 0; r < 16; r++) begin
      dbg_raddr = r[3:0];
      #1;
      n_checks++;
      if (dbg_rdata !== 16'h0) begin
        n_fail++;
        $display("[TB] FAIL reset_reg[%0d]: got %h, expected 0000", r, dbg_rdata);
      end
    end
  endtask

  task automatic test_load_add();
    instr_t seq [8];
    seq[0] = mk(4'd14, 4'd0,  4'd0, 4'd6,  8'h10, 16'hFFFF, 4'b1000);
    seq[1] = mk(4'd8,  4'd6,  4'd0, 4'd7,  8'h11, 16'h0001, 4'b0000);
    seq[2] = mk(4'd11, 4'd7,  4'd0, 4'd8,  8'h12, 16'h0002, 4'b0000);
    seq[3] = mk(4'd11, 4'd8,  4'd0, 4'd9,  8'h13, 16'h0004, 4'b0000);
    seq[4] = mk(4'd0,  4'd9,  4'd7, 4'd1,  8'h14, 16'h0005, 4'b0000);
    seq[5] = mk(4'd0,  4'd8,  4'd7, 4'd10, 8'h15, 16'h0003, 4'b0000);
    seq[6] = mk(4'd3,  4'd10, 4'd0, 4'd2,  8'h16, 16'h0003, 4'b0000);
    seq[7] = mk(4'd0,  4'd1,  4'd2, 4'd3,  8'h17, 16'h0008, 4'b0000);
    for (int i = 0; i < 10; i++) begin
      if (i < 8) drive(seq[i]); else in_valid = 1'b0;
      tick();
      if (i >= 2) begin
        n_checks++;
        if (out_valid !== 1'b1 || z_out !== seq[i-2].z || flags !== seq[i-2].fl) begin
          n_fail++;
          $display("[TB] FAIL load_add[%0d]: out_valid=%b z_out=%h flags=%b, expected 1 %h %b",
                   i-2, out_valid, z_out, flags, seq[i-2].z, seq[i-2].fl);
        end
      end
    end
    dbg_raddr = 4'd3; dbg_maddr = 8'h17;
    #1;
    n_checks++;
    if (dbg_rdata !== 16'h0008) begin
      n_fail++;
      $display("[TB] FAIL load_add_r3: got %h, expected 0008", dbg_rdata);
    end
    tick();
    n_checks++;
    if (dbg_mdata !== 16'h0008) begin
      n_fail++;
      $display("[TB] FAIL load_add_mem: got %h, expected 0008", dbg_mdata);
    end
    n_checks++;
    if (out_valid !== 1'b0 || z_out !== 16'h0008) begin
      n_fail++;
      $display("[TB] FAIL bubble_hold: out_valid=%b z_out=%h, expected 0 0008", out_valid, z_out);
    end
  endtask

  task automatic test_back_to_back();
    instr_t seq [4];
    seq[0] = mk(4'd0, 4'd3,  4'd3, 4'd4,  8'h20, 16'h0010, 4'b0000);
    seq[1] = mk(4'd1, 4'd4,  4'd1, 4'd5,  8'h21, 16'h000B, 4'b0000);
    seq[2] = mk(4'd0, 4'd4,  4'd5, 4'd11, 8'h22, 16'h001B, 4'b0000);
    seq[3] = mk(4'd1, 4'd11, 4'd4, 4'd12, 8'h23, 16'h000B, 4'b0000);
    for (int i = 0; i < 6; i++) begin
      if (i < 4) drive(seq[i]); else in_valid = 1'b0;
      tick();
      if (i >= 2) begin
        n_checks++;
        if (out_valid !== 1'b1 || z_out !== seq[i-2].z || flags !== seq[i-2].fl) begin
          n_fail++;
          $display("[TB] FAIL chain[%0d]: out_valid=%b z_out=%h flags=%b, expected 1 %h %b",
                   i-2, out_valid, z_out, flags, seq[i-2].z, seq[i-2].fl);
        end
      end
    end
    tick();
    dbg_raddr = 4'd5; dbg_maddr = 8'h22;
    #1;
    n_checks++;
    if (dbg_rdata !== 16'h000B || dbg_mdata !== 16'h001B) begin
      n_fail++;
      $display("[TB] FAIL chain_state: r5=%h mem22=%h, expected 000B 001B", dbg_rdata, dbg_mdata);
    end
  endtask

  task automatic test_flags();
    instr_t seq [15];
    seq[0]  = mk(4'd10, 4'd6,  4'd0,  4'd13, 8'h30, 16'h7FFF, 4'b0000);
    seq[1]  = mk(4'd0,  4'd13, 4'd7,  4'd14, 8'h31, 16'h8000, 4'b1001);
    seq[2]  = mk(4'd0,  4'd6,  4'd7,  4'd15, 8'h32, 16'h0000, 4'b0110);
    seq[3]  = mk(4'd1,  4'd0,  4'd7,  4'd12, 8'h33, 16'hFFFF, 4'b1010);
    seq[4]  = mk(4'd15, 4'd6,  4'd7,  4'd11, 8'h34, 16'h0001, 4'b0000);
    seq[5]  = mk(4'd2,  4'd13, 4'd8,  4'd10, 8'h35, 16'hFFFE, 4'b1000);
    seq[6]  = mk(4'd8,  4'd14, 4'd0,  4'd9,  8'h36, 16'h8000, 4'b1001);
    seq[7]  = mk(4'd12, 4'd14, 4'd0,  4'd8,  8'h37, 16'hC000, 4'b1000);
    seq[8]  = mk(4'd13, 4'd14, 4'd0,  4'd7,  8'h38, 16'h0001, 4'b0000);
    seq[9]  = mk(4'd5,  4'd6,  4'd13, 4'd1,  8'h39, 16'h7FFF, 4'b0000);
    seq[10] = mk(4'd6,  4'd13, 4'd14, 4'd2,  8'h3A, 16'hFFFF, 4'b1000);
    seq[11] = mk(4'd7,  4'd6,  4'd13, 4'd3,  8'h3B, 16'h8000, 4'b1000);
    seq[12] = mk(4'd4,  4'd0,  4'd13, 4'd4,  8'h3C, 16'h7FFF, 4'b0000);
    seq[13] = mk(4'd9,  4'd0,  4'd7,  4'd5,  8'h3D, 16'hFFFF, 4'b1000);
    seq[14] = mk(4'd15, 4'd7,  4'd6,  4'd0,  8'h3E, 16'h0000, 4'b0100);
    for (int i = 0; i < 17; i++) begin
      if (i < 15) drive(seq[i]); else in_valid = 1'b0;
      tick();
      if (i >= 2) begin
        n_checks++;
        if (out_valid !== 1'b1 || z_out !== seq[i-2].z || flags !== seq[i-2].fl) begin
          n_fail++;
          $display("[TB] FAIL flags[%0d] op %0d: out_valid=%b z_out=%h flags=%b, expected 1 %h %b",
                   i-2, seq[i-2].func, out_valid, z_out, flags, seq[i-2].z, seq[i-2].fl);
        end
      end
    end
    tick();
  endtask

  task automatic test_stall();
    instr_t seq [3];
    seq[0] = mk(4'd0, 4'd7, 4'd7, 4'd1, 8'h40, 16'h0002, 4'b0000);
    seq[1] = mk(4'd0, 4'd1, 4'd7, 4'd2, 8'h41, 16'h0003, 4'b0000);
    seq[2] = mk(4'd0, 4'd2, 4'd1, 4'd3, 8'h42, 16'h0005, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      drive(seq[i]);
      tick();
    end
    stall = 1'b1;
    drive(mk(4'd3, 4'd6, 4'd0, 4'd15, 8'h43, 16'h0, 4'h0));
    for (int i = 0; i < 3; i++) begin
      in_valid = (i != 1);
      tick();
      dbg_raddr = 4'd2; dbg_maddr = 8'h40;
      #1;
      n_checks++;
      if (out_valid !== 1'b1 || z_out !== 16'h0002 || dbg_rdata !== 16'hFFFF || dbg_mdata === 16'h0002) begin
        n_fail++;
        $display("[TB] FAIL stall_freeze[%0d]: out_valid=%b z_out=%h r2=%h mem40=%h, expected 1 0002 FFFF !0002",
                 i, out_valid, z_out, dbg_rdata, dbg_mdata);
      end
    end
    stall = 1'b0; in_valid = 1'b0;
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || z_out !== 16'h0003) begin
      n_fail++;
      $display("[TB] FAIL stall_resume_b: out_valid=%b z_out=%h, expected 1 0003", out_valid, z_out);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || z_out !== 16'h0005) begin
      n_fail++;
      $display("[TB] FAIL stall_resume_c: out_valid=%b z_out=%h, expected 1 0005", out_valid, z_out);
    end
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      dbg_maddr = 8'h40 + i[7:0];
      #1;
      n_checks++;
      if (dbg_mdata !== seq[i].z) begin
        n_fail++;
        $display("[TB] FAIL stall_mem[%0d]: got %h, expected %h", i, dbg_mdata, seq[i].z);
      end
    end
    dbg_raddr = 4'd15; dbg_maddr = 8'h43;
    #1;
    n_checks++;
    if (dbg_rdata !== 16'h0000 || dbg_mdata === 16'hFFFF) begin
      n_fail++;
      $display("[TB] FAIL stall_ignored_input: r15=%h mem43=%h, expected 0000 !FFFF", dbg_rdata, dbg_mdata);
    end
  endtask

  task automatic test_reset_midstream();
    instr_t seq [3];
    seq[0] = mk(4'd0, 4'd7, 4'd7, 4'd4, 8'h50, 16'h0002, 4'b0000);
    seq[1] = mk(4'd3, 4'd8, 4'd0, 4'd5, 8'h51, 16'hC000, 4'b1000);
    seq[2] = mk(4'd3, 4'd9, 4'd0, 4'd6, 8'h52, 16'h8000, 4'b1000);
    for (int i = 0; i < 3; i++) begin
      drive(seq[i]);
      tick();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || z_out !== 16'h0 || flags !== 4'h0) begin
      n_fail++;
      $display("[TB] FAIL midreset_outputs: out_valid=%b z_out=%h flags=%b, expected 0 0000 0000", out_valid, z_out, flags);
    end
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    n_checks++;
    if (out_valid !== 1'b0 || z_out !== 16'h0) begin
      n_fail++;
      $display("[TB] FAIL midreset_after: out_valid=%b z_out=%h, expected 0 0000", out_valid, z_out);
    end
    for (int i = 0; i < 3; i++) begin
      dbg_raddr = seq[i].rd; dbg_maddr = seq[i].addr;
      #1;
      n_checks++;
      if (dbg_rdata !== 16'h0 || dbg_mdata === seq[i].z) begin
        n_fail++;
        $display("[TB] FAIL midreset_discard[%0d]: reg=%h mem=%h, expected 0000 and mem != %h",
                 i, dbg_rdata, dbg_mdata, seq[i].z);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_add();
    test_back_to_back();
    test_flags();
    test_stall();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
